// File: rtl/key_mode_ctrl.sv
// Debounces two active-low keys into MODE/SPEED/PAUSE controls for the breathing-LED stage.
// Optional macro LONG_PRESS_EN enables long-press detection (HELD state, PAUSE, both-keys clear).
module key_mode_ctrl #(
    parameter int unsigned CLOCK_FRQ     = 50000000,
    parameter int unsigned DEBOUNCE_MS   = 20,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] KEY,
    output logic [1:0] MODE,
    output logic [2:0] SPEED,
    output logic       PAUSE,
    output logic       KEY_EVT
);

    localparam int unsigned DB_CYC = (CLOCK_FRQ / 1000) * DEBOUNCE_MS;
    localparam int unsigned DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

`ifdef LONG_PRESS_EN
    localparam int unsigned LP_CYC = (CLOCK_FRQ / 1000) * LONG_PRESS_MS;
    localparam int unsigned LP_W   = (LP_CYC > 1) ? $clog2(LP_CYC) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYC - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [DB_W-1:0] db_cnt [2];
    state_t          st [2];
    logic [1:0]      short_c;

`ifdef LONG_PRESS_EN
    logic [LP_W-1:0] hold_cnt [2];
    logic [1:0]      long_c;
    logic            clear_all_c;
`endif

    // Two-flop synchroniser and per-key debounce counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            deb   <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Press events decoded from the current state and debounced level
    always_comb begin
        short_c = 2'b00;
`ifdef LONG_PRESS_EN
        long_c  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (st[i] == PRESSED) begin
                if (deb[i]) begin
                    short_c[i] = 1'b1;
                end else if (hold_cnt[i] == LP_LAST) begin
                    long_c[i] = 1'b1;
                end
            end
        end
        // Second key reaching HELD while the other is already (or simultaneously) HELD
        clear_all_c = (long_c[0] && (long_c[1] || st[1] == HELD)) ||
                      (long_c[1] && st[0] == HELD);
`else
        for (int i = 0; i < 2; i++) begin
            if (st[i] == IDLE && !deb[i]) begin
                short_c[i] = 1'b1;
            end
        end
`endif
    end

    // Per-key press FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                st[i] <= IDLE;
`ifdef LONG_PRESS_EN
                hold_cnt[i] <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (st[i])
                    IDLE: begin
                        if (!deb[i]) begin
                            st[i] <= PRESSED;
`ifdef LONG_PRESS_EN
                            hold_cnt[i] <= '0;
`endif
                        end
                    end
                    PRESSED: begin
`ifdef LONG_PRESS_EN
                        if (deb[i]) begin
                            st[i] <= IDLE;
                        end else if (hold_cnt[i] == LP_LAST) begin
                            st[i] <= HELD;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + LP_W'(1);
                        end
`else
                        if (deb[i]) begin
                            st[i] <= IDLE;
                        end
`endif
                    end
                    HELD: begin
                        if (deb[i]) begin
                            st[i] <= IDLE;
                        end
                    end
                    default: st[i] <= IDLE;
                endcase
            end
        end
    end

    // Registered actions, one cycle after the FSM event
    always_ff @(posedge CLK) begin
        if (RST) begin
            MODE    <= 2'd0;
            SPEED   <= 3'd0;
            PAUSE   <= 1'b0;
            KEY_EVT <= 1'b0;
        end else begin
            if (short_c[0]) begin
                MODE <= MODE + 2'd1;
            end
            if (short_c[1]) begin
                SPEED <= SPEED + 3'd1;
            end
`ifdef LONG_PRESS_EN
            KEY_EVT <= (|short_c) | (|long_c);
            if (clear_all_c) begin
                MODE  <= 2'd0;
                SPEED <= 3'd0;
                PAUSE <= 1'b0;
            end else begin
                if (long_c[0]) begin
                    PAUSE <= ~PAUSE;
                end
                if (long_c[1]) begin
                    SPEED <= 3'd0;
                end
            end
`else
            KEY_EVT <= |short_c;
            PAUSE   <= 1'b0;
`endif
        end
    end

endmodule
